// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operation sequencer: op encodings,
// sequencer states, error bit positions and the unit one-hot helper.
package fpu_pkg;

  localparam int NUM_UNITS = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_TIMEOUT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // One-hot unit select for an op; illegal ops (5-7) map to no unit.
  function automatic logic [NUM_UNITS-1:0] op_onehot(input logic [2:0] op);
    return NUM_UNITS'(1) << op;
  endfunction

endpackage

// File: rtl/fpu_seq_timer.sv
// Clearable up-counter with a terminal-count flag, used to bound how long
// the sequencer waits for a unit's done pulse.
module fpu_seq_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues one FPU operation at a time: latches a command, pulses the chosen
// unit's start, waits (bounded) for its done, captures the mux output and
// holds it until the requester takes it.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [DATA_W-1:0]    cmd_a,
  input  logic [DATA_W-1:0]    cmd_b,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [DATA_W-1:0]    unit_a,
  output logic [DATA_W-1:0]    unit_b,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [2:0]           mux_op,
  input  logic [DATA_W-1:0]    mux_result,
  input  logic                 mux_eq,
  input  logic                 mux_gt,
  input  logic                 mux_lt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic [2:0]           res_flags,
  output logic [1:0]           res_err,
  output logic                 busy
);

  seq_state_e        state_q, state_d;
  logic [2:0]        mux_op_q, mux_op_d;
  logic [DATA_W-1:0] unit_a_q, unit_a_d;
  logic [DATA_W-1:0] unit_b_q, unit_b_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [2:0]        res_flags_q, res_flags_d;
  logic [1:0]        res_err_q, res_err_d;
  logic              tmr_clr, tmr_en, tmr_tc;
  logic              done_hit;

  fpu_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  // Only the done bit of the unit we started counts.
  assign done_hit = |(unit_done & op_onehot(mux_op_q));

  // Next-state and capture logic; done beats a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    mux_op_d    = mux_op_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mux_op_d = cmd_op;
          unit_a_d = cmd_a;
          unit_b_d = cmd_b;
          if (cmd_op > OP_CMP) begin
            res_data_d             = '0;
            res_flags_d            = '0;
            res_err_d              = '0;
            res_err_d[ERR_ILLEGAL] = 1'b1;
            state_d                = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (done_hit) begin
          res_err_d = '0;
          if (mux_op_q == OP_CMP) begin
            res_data_d  = '0;
            res_flags_d = {mux_eq, mux_gt, mux_lt};
          end else begin
            res_data_d  = mux_result;
            res_flags_d = '0;
          end
          state_d = ST_RESP;
        end else if (tmr_tc) begin
          res_data_d             = '0;
          res_flags_d            = '0;
          res_err_d              = '0;
          res_err_d[ERR_TIMEOUT] = 1'b1;
          state_d                = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mux_op_q    <= '0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      mux_op_q    <= mux_op_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
    end
  end

  assign unit_start = (state_q == ST_ISSUE) ? op_onehot(mux_op_q) : '0;
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign res_valid  = (state_q == ST_RESP);
  assign mux_op     = mux_op_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign res_err    = res_err_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: directed and randomized transactions scored
// against expected results, latencies and hold behaviour derived from the
// operation rules.
module tb_fpu_op_sequencer;

  localparam int DATA_W = 32;
  localparam int TO     = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [4:0]        unit_start;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic [4:0]        unit_done = '0;
  logic [2:0]        mux_op;
  logic [DATA_W-1:0] mux_result = '0;
  logic              mux_eq = 1'b0;
  logic              mux_gt = 1'b0;
  logic              mux_lt = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic [2:0]        res_flags;
  logic [1:0]        res_err;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .unit_start(unit_start),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .unit_done (unit_done),
    .mux_op    (mux_op),
    .mux_result(mux_result),
    .mux_eq    (mux_eq),
    .mux_gt    (mux_gt),
    .mux_lt    (mux_lt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_err   (res_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command/response exchange.
  // k: WAIT cycle (1-based) in which the right done arrives; k > TO means never.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int k, input bit wrong, input bit issue_noise, input int hold,
                        input logic [31:0] r, input logic [2:0] f);
    logic [31:0] e_data;
    logic [2:0]  e_flags;
    logic [1:0]  e_err;
    int          e_lat;
    int          c;
    int          other;
    if (op > 3'd4) begin
      e_data = '0; e_flags = '0; e_err = 2'b01; e_lat = 1;
    end else if (k > TO) begin
      e_data = '0; e_flags = '0; e_err = 2'b10; e_lat = TO + 2;
    end else begin
      e_data  = (op == 3'd4) ? 32'd0 : r;
      e_flags = (op == 3'd4) ? f : 3'd0;
      e_err   = 2'b00;
      e_lat   = k + 2;
    end

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;

    c = 1;
    while (!res_valid && c <= TO + 8) begin
      check("unit_start", unit_start, (c == 1) ? (5'b1 << op) : 5'b0);
      check("busy", busy, 1);
      check("cmd_ready_busy", cmd_ready, 0);
      check("mux_op", mux_op, op);
      check("unit_a", unit_a, a);
      check("unit_b", unit_b, b);
      unit_done  = '0;
      mux_result = $urandom;
      {mux_eq, mux_gt, mux_lt} = 3'($urandom);
      if (c == 1 && issue_noise) begin
        unit_done = 5'b1 << op;
      end else if (c == k + 1) begin
        unit_done  = 5'b1 << op;
        mux_result = r;
        {mux_eq, mux_gt, mux_lt} = f;
      end else if (wrong && c >= 2 && $urandom_range(0, 2) == 0) begin
        other     = (int'(op) + 1 + int'($urandom_range(0, 3))) % 5;
        unit_done = 5'b1 << other;
      end
      tick();
      unit_done = '0;
      c++;
    end
    check("latency", c, e_lat);
    if (!res_valid) begin
      rst = 1'b1; #1; rst = 1'b0;
      return;
    end

    check("res_data", res_data, e_data);
    check("res_flags", res_flags, e_flags);
    check("res_err", res_err, e_err);
    check("resp_start", unit_start, 0);
    check("resp_cmd_ready", cmd_ready, 0);
    check("resp_mux_op", mux_op, op);

    for (int h = 0; h < hold; h++) begin
      res_ready  = 1'b0;
      unit_done  = 5'($urandom);
      mux_result = $urandom;
      {mux_eq, mux_gt, mux_lt} = 3'($urandom);
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, e_data);
      check("hold_flags", res_flags, e_flags);
      check("hold_err", res_err, e_err);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_start", unit_start, 0);
    end
    unit_done = '0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
    check("post_mux_op", mux_op, op);
    check("post_unit_a", unit_a, a);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rk;

    #12;
    check("rst_start", unit_start, 0);
    check("rst_unit_a", unit_a, 0);
    check("rst_unit_b", unit_b, 0);
    check("rst_mux_op", mux_op, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_flags", res_flags, 0);
    check("rst_err", res_err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // add 1.0 + 2.0, done three cycles after the start pulse
    do_txn(3'd0, 32'h3F800000, 32'h40000000, 3, 1'b0, 1'b0, 0, 32'h40400000, 3'b000);
    // compare reporting greater-than
    do_txn(3'd4, 32'h40000000, 32'h3F800000, 2, 1'b0, 1'b0, 0, 32'hDEADBEEF, 3'b010);
    // illegal op held five cycles before being taken
    do_txn(3'd6, 32'h12345678, 32'h9ABCDEF0, 1, 1'b0, 1'b0, 5, 32'h0, 3'b000);
    // divide that never finishes, then one finishing on the last allowed cycle
    do_txn(3'd3, 32'h11111111, 32'h22222222, TO + 1, 1'b0, 1'b0, 1, 32'h55555555, 3'b000);
    do_txn(3'd3, 32'h33333333, 32'h44444444, TO, 1'b0, 1'b0, 0, 32'h66666666, 3'b000);
    // multiply with stray done pulses from other units and during ISSUE
    do_txn(3'd2, 32'h40400000, 32'h40800000, 12, 1'b1, 1'b1, 0, 32'h41400000, 3'b000);
    // fastest completion, back to back
    do_txn(3'd1, 32'h40800000, 32'h3F800000, 1, 1'b0, 1'b0, 0, 32'h40400000, 3'b000);
    do_txn(3'd0, 32'h00000001, 32'h00000002, 1, 1'b0, 1'b1, 0, 32'h00000003, 3'b000);

    // reset in the middle of a WAIT drops the operation
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 32'hA5A5A5A5; cmd_b = 32'h5A5A5A5A;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_unit_a", unit_a, 0);
    check("mid_rst_mux_op", mux_op, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_err", res_err, 0);
    #2;
    rst = 1'b0;
    unit_done = 5'b01000;
    mux_result = 32'hFFFFFFFF;
    tick();
    unit_done = '0;
    check("late_done_valid", res_valid, 0);
    check("late_done_busy", busy, 0);
    check("late_done_start", unit_start, 0);
    check("late_done_data", res_data, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 9) == 0) rk = TO + int'($urandom_range(0, 1));
      else rk = int'($urandom_range(1, 10));
      do_txn(rop, ra, rb, rk, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
             $urandom, 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
